// File: rtl/alu_issue.sv
// RV32I integer decode-and-issue stage: decodes an instruction into ALU select and operands,
// presents them for one cycle, and captures the ALU result into a writeback register.
module alu_issue #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inValid,
  output logic            inReady,
  input  logic [31:0]     inInstr,
  input  logic [XLEN-1:0] inPc,
  input  logic [XLEN-1:0] inRs1,
  input  logic [XLEN-1:0] inRs2,
  output logic [3:0]      aluOutSel,
  output logic [XLEN-1:0] opA,
  output logic [XLEN-1:0] opB,
  input  logic [XLEN-1:0] aluOut,
  output logic            wbValid,
  input  logic            wbReady,
  output logic [4:0]      wbRd,
  output logic            wbWe,
  output logic [XLEN-1:0] wbData,
  output logic            wbIllegal
);

  localparam logic [3:0] SEL_ADD  = 4'b0000;
  localparam logic [3:0] SEL_SUB  = 4'b0001;
  localparam logic [3:0] SEL_XOR  = 4'b0010;
  localparam logic [3:0] SEL_OR   = 4'b0011;
  localparam logic [3:0] SEL_AND  = 4'b0100;
  localparam logic [3:0] SEL_SLT  = 4'b0101;
  localparam logic [3:0] SEL_SLTU = 4'b0110;
  localparam logic [3:0] SEL_SLL  = 4'b0111;
  localparam logic [3:0] SEL_SRL  = 4'b1000;
  localparam logic [3:0] SEL_SRA  = 4'b1001;
  localparam logic [3:0] SEL_PASS = 4'b1111;

  localparam logic [6:0] OPC_OP    = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // Instruction fields
  logic [6:0] opcode;
  logic [4:0] rd;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       f7_base;
  logic       f7_alt;

  assign opcode  = inInstr[6:0];
  assign rd      = inInstr[11:7];
  assign funct3  = inInstr[14:12];
  assign funct7  = inInstr[31:25];
  assign f7_base = (funct7 == F7_BASE);
  assign f7_alt  = (funct7 == F7_ALT);

  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] shamt_rs2;
  logic [XLEN-1:0] shamt_imm;

  assign imm_i = {{(XLEN-12){inInstr[31]}}, inInstr[31:20]};
  assign imm_u = {inInstr[31:12], 12'h000};

  // Shift amounts keep only the low five bits; everything above is forced to zero.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_shamt
      if (gi < 5) begin : g_lo
        assign shamt_rs2[gi] = inRs2[gi];
        assign shamt_imm[gi] = inInstr[20+gi];
      end else begin : g_hi
        assign shamt_rs2[gi] = 1'b0;
        assign shamt_imm[gi] = 1'b0;
      end
    end
  endgenerate

  // Register-register ops
  logic [3:0]      op_sel;
  logic            op_legal;
  logic            op_shift;

  always_comb begin
    op_sel   = SEL_PASS;
    op_legal = 1'b0;
    op_shift = 1'b0;
    unique case (funct3)
      3'b000: begin
        if (f7_base) begin
          op_sel   = SEL_ADD;
          op_legal = 1'b1;
        end else if (f7_alt) begin
          op_sel   = SEL_SUB;
          op_legal = 1'b1;
        end
      end
      3'b001: begin
        op_sel   = SEL_SLL;
        op_legal = f7_base;
        op_shift = 1'b1;
      end
      3'b010: begin
        op_sel   = SEL_SLT;
        op_legal = f7_base;
      end
      3'b011: begin
        op_sel   = SEL_SLTU;
        op_legal = f7_base;
      end
      3'b100: begin
        op_sel   = SEL_XOR;
        op_legal = f7_base;
      end
      3'b101: begin
        op_shift = 1'b1;
        if (f7_base) begin
          op_sel   = SEL_SRL;
          op_legal = 1'b1;
        end else if (f7_alt) begin
          op_sel   = SEL_SRA;
          op_legal = 1'b1;
        end
      end
      3'b110: begin
        op_sel   = SEL_OR;
        op_legal = f7_base;
      end
      default: begin
        op_sel   = SEL_AND;
        op_legal = f7_base;
      end
    endcase
  end

  // Register-immediate ops; only the shifts look at funct7
  logic [3:0]      opi_sel;
  logic            opi_legal;
  logic            opi_shift;

  always_comb begin
    opi_sel   = SEL_PASS;
    opi_legal = 1'b1;
    opi_shift = 1'b0;
    unique case (funct3)
      3'b000: opi_sel = SEL_ADD;
      3'b001: begin
        opi_sel   = SEL_SLL;
        opi_legal = f7_base;
        opi_shift = 1'b1;
      end
      3'b010: opi_sel = SEL_SLT;
      3'b011: opi_sel = SEL_SLTU;
      3'b100: opi_sel = SEL_XOR;
      3'b101: begin
        opi_shift = 1'b1;
        if (f7_base) begin
          opi_sel = SEL_SRL;
        end else if (f7_alt) begin
          opi_sel = SEL_SRA;
        end else begin
          opi_legal = 1'b0;
        end
      end
      3'b110: opi_sel = SEL_OR;
      default: opi_sel = SEL_AND;
    endcase
  end

  // Final decode
  logic [3:0]      dec_sel;
  logic [XLEN-1:0] dec_opa;
  logic [XLEN-1:0] dec_opb;
  logic            dec_illegal;
  logic            dec_we;

  always_comb begin
    dec_sel     = SEL_PASS;
    dec_opa     = '0;
    dec_opb     = '0;
    dec_illegal = 1'b1;
    unique case (opcode)
      OPC_OP: begin
        if (op_legal) begin
          dec_sel     = op_sel;
          dec_opa     = inRs1;
          dec_opb     = op_shift ? shamt_rs2 : inRs2;
          dec_illegal = 1'b0;
        end
      end
      OPC_OPIMM: begin
        if (opi_legal) begin
          dec_sel     = opi_sel;
          dec_opa     = inRs1;
          dec_opb     = opi_shift ? shamt_imm : imm_i;
          dec_illegal = 1'b0;
        end
      end
      OPC_LUI: begin
        dec_sel     = SEL_PASS;
        dec_opa     = imm_u;
        dec_opb     = '0;
        dec_illegal = 1'b0;
      end
      OPC_AUIPC: begin
        dec_sel     = SEL_ADD;
        dec_opa     = inPc;
        dec_opb     = imm_u;
        dec_illegal = 1'b0;
      end
      default: begin
        dec_illegal = 1'b1;
      end
    endcase
  end

  assign dec_we = !dec_illegal && (rd != 5'd0);

  // Handshake
  logic            s1_valid_reg;
  logic            s1_valid_next;
  logic [3:0]      sel_reg;
  logic [XLEN-1:0] opa_reg;
  logic [XLEN-1:0] opb_reg;
  logic [4:0]      s1_rd_reg;
  logic            s1_we_reg;
  logic            s1_ill_reg;

  logic            wb_valid_reg;
  logic            wb_valid_next;
  logic [4:0]      wb_rd_reg;
  logic            wb_we_reg;
  logic [XLEN-1:0] wb_data_reg;
  logic            wb_ill_reg;

  logic            s1_adv;
  logic            in_fire;
  logic            wb_fire;

  assign s1_adv  = s1_valid_reg && (!wb_valid_reg || wbReady);
  assign inReady = !s1_valid_reg || s1_adv;
  assign in_fire = inValid && inReady;
  assign wb_fire = wb_valid_reg && wbReady;

  always_comb begin
    s1_valid_next = s1_valid_reg;
    if (in_fire) begin
      s1_valid_next = 1'b1;
    end else if (s1_adv) begin
      s1_valid_next = 1'b0;
    end
  end

  always_comb begin
    wb_valid_next = wb_valid_reg;
    if (s1_adv) begin
      wb_valid_next = 1'b1;
    end else if (wb_fire) begin
      wb_valid_next = 1'b0;
    end
  end

  // S1: ALU-facing registers hold their last values while idle or stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      sel_reg      <= SEL_PASS;
      opa_reg      <= '0;
      opb_reg      <= '0;
      s1_rd_reg    <= 5'd0;
      s1_we_reg    <= 1'b0;
      s1_ill_reg   <= 1'b0;
    end else begin
      s1_valid_reg <= s1_valid_next;
      if (in_fire) begin
        sel_reg    <= dec_sel;
        opa_reg    <= dec_opa;
        opb_reg    <= dec_opb;
        s1_rd_reg  <= rd;
        s1_we_reg  <= dec_we;
        s1_ill_reg <= dec_illegal;
      end
    end
  end

  // S2: the ALU result settles within the cycle S1 presents operands
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_valid_reg <= 1'b0;
      wb_rd_reg    <= 5'd0;
      wb_we_reg    <= 1'b0;
      wb_data_reg  <= '0;
      wb_ill_reg   <= 1'b0;
    end else begin
      wb_valid_reg <= wb_valid_next;
      if (s1_adv) begin
        wb_rd_reg   <= s1_rd_reg;
        wb_we_reg   <= s1_we_reg;
        wb_data_reg <= s1_ill_reg ? '0 : aluOut;
        wb_ill_reg  <= s1_ill_reg;
      end
    end
  end

  assign aluOutSel = sel_reg;
  assign opA       = opa_reg;
  assign opB       = opb_reg;
  assign wbValid   = wb_valid_reg;
  assign wbRd      = wb_rd_reg;
  assign wbWe      = wb_we_reg;
  assign wbData    = wb_data_reg;
  assign wbIllegal = wb_ill_reg;

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue: a behavioural ALU closes the loop and each task checks one feature.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic        inReady;
  logic [31:0] inInstr;
  logic [31:0] inPc;
  logic [31:0] inRs1;
  logic [31:0] inRs2;
  logic [3:0]  aluOutSel;
  logic [31:0] opA;
  logic [31:0] opB;
  logic [31:0] aluOut;
  logic        wbValid;
  logic        wbReady;
  logic [4:0]  wbRd;
  logic        wbWe;
  logic [31:0] wbData;
  logic        wbIllegal;

  int vectors = 0;
  int miscompares = 0;

  alu_issue #(.XLEN(32)) dut (
    .clk(clk), .rst(rst),
    .inValid(inValid), .inReady(inReady), .inInstr(inInstr), .inPc(inPc),
    .inRs1(inRs1), .inRs2(inRs2),
    .aluOutSel(aluOutSel), .opA(opA), .opB(opB), .aluOut(aluOut),
    .wbValid(wbValid), .wbReady(wbReady), .wbRd(wbRd), .wbWe(wbWe),
    .wbData(wbData), .wbIllegal(wbIllegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU on the far side of the select/operand interface
  always_comb begin
    aluOut = 32'h0;
    case (aluOutSel)
      4'b0000: aluOut = opA + opB;
      4'b0001: aluOut = opA - opB;
      4'b0010: aluOut = opA ^ opB;
      4'b0011: aluOut = opA | opB;
      4'b0100: aluOut = opA & opB;
      4'b0101: aluOut = ($signed(opA) < $signed(opB)) ? 32'd1 : 32'd0;
      4'b0110: aluOut = (opA < opB) ? 32'd1 : 32'd0;
      4'b0111: aluOut = opA << opB[4:0];
      4'b1000: aluOut = opA >> opB[4:0];
      4'b1001: aluOut = $unsigned($signed(opA) >>> opB[4:0]);
      4'b1111: aluOut = opA;
      default: aluOut = 32'h0;
    endcase
  end

  function automatic logic [31:0] r_type(input logic [6:0] f7, input logic [4:0] rs2,
                                         input logic [4:0] rs1, input logic [2:0] f3,
                                         input logic [4:0] rd, input logic [6:0] opc);
    return {f7, rs2, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] i_type(input logic [11:0] imm, input logic [4:0] rs1,
                                         input logic [2:0] f3, input logic [4:0] rd,
                                         input logic [6:0] opc);
    return {imm, rs1, f3, rd, opc};
  endfunction

  localparam logic [6:0] OP    = 7'b0110011;
  localparam logic [6:0] OPIMM = 7'b0010011;

  // Values observed by issue(): S1 one cycle after accept, S2 two cycles after
  logic [3:0]  obs_sel;
  logic [31:0] obs_a, obs_b, obs_data;
  logic        obs_wbv_early, obs_wbv, obs_we, obs_ill;
  logic [4:0]  obs_rd;

  task automatic issue(input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    @(negedge clk);
    wbReady = 1'b1;
    inValid = 1'b1;
    inInstr = instr;
    inPc    = pc;
    inRs1   = rs1;
    inRs2   = rs2;
    @(negedge clk);
    inValid       = 1'b0;
    obs_sel       = aluOutSel;
    obs_a         = opA;
    obs_b         = opB;
    obs_wbv_early = wbValid;
    @(negedge clk);
    obs_wbv  = wbValid;
    obs_rd   = wbRd;
    obs_we   = wbWe;
    obs_data = wbData;
    obs_ill  = wbIllegal;
    $display("txn instr=%h sel=%h opA=%h opB=%h wbValid=%b rd=%0d we=%b ill=%b data=%h",
             instr, obs_sel, obs_a, obs_b, obs_wbv, obs_rd, obs_we, obs_ill, obs_data);
  endtask

  task automatic test_reset();
    rst = 1'b1; inValid = 1'b0; wbReady = 1'b1;
    inInstr = 32'h0; inPc = 32'h0; inRs1 = 32'h0; inRs2 = 32'h0;
    #12;
    vectors++; if (aluOutSel !== 4'b1111) begin miscompares++; $display("FAIL reset_sel: got %h want f", aluOutSel); end
    vectors++; if ({opA, opB} !== 64'h0) begin miscompares++; $display("FAIL reset_ops: got %h %h want 0 0", opA, opB); end
    vectors++; if ({wbValid, wbRd, wbWe, wbIllegal} !== 8'h0 || wbData !== 32'h0) begin
      miscompares++; $display("FAIL reset_wb: got v=%b rd=%0d we=%b ill=%b data=%h want all 0", wbValid, wbRd, wbWe, wbIllegal, wbData); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vectors++; if (inReady !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", inReady); end
    $display("txn reset released");
  endtask

  task automatic test_add();
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd3, OP), 32'h0, 32'd5, 32'd7);
    vectors++; if (obs_sel !== 4'b0000) begin miscompares++; $display("FAIL add_sel: got %h want 0", obs_sel); end
    vectors++; if (obs_a !== 32'd5 || obs_b !== 32'd7) begin miscompares++; $display("FAIL add_ops: got %h %h want 5 7", obs_a, obs_b); end
    vectors++; if (obs_wbv_early !== 1'b0) begin miscompares++; $display("FAIL add_latency: wbValid %b one cycle after accept, want 0", obs_wbv_early); end
    vectors++; if (obs_wbv !== 1'b1 || obs_rd !== 5'd3 || obs_we !== 1'b1) begin
      miscompares++; $display("FAIL add_wb: got v=%b rd=%0d we=%b want 1 3 1", obs_wbv, obs_rd, obs_we); end
    vectors++; if (obs_data !== 32'd12) begin miscompares++; $display("FAIL add_data: got %h want c", obs_data); end
    @(negedge clk);
    vectors++; if (wbValid !== 1'b0) begin miscompares++; $display("FAIL add_retire: wbValid %b want 0", wbValid); end
  endtask

  task automatic test_shift();
    issue(r_type(7'b0100000, 5'd2, 5'd1, 3'b101, 5'd4, OP), 32'h0, 32'h80000000, 32'hFFFFFF24);
    vectors++; if (obs_sel !== 4'b1001 || obs_b !== 32'd4) begin miscompares++; $display("FAIL sra_ops: got sel=%h opB=%h want 9 4", obs_sel, obs_b); end
    vectors++; if (obs_data !== 32'hF8000000) begin miscompares++; $display("FAIL sra_data: got %h want f8000000", obs_data); end
    issue(i_type(12'h41F, 5'd1, 3'b101, 5'd6, OPIMM), 32'h0, 32'h80000000, 32'h0);
    vectors++; if (obs_sel !== 4'b1001 || obs_b !== 32'd31) begin miscompares++; $display("FAIL srai_ops: got sel=%h opB=%h want 9 1f", obs_sel, obs_b); end
    vectors++; if (obs_data !== 32'hFFFFFFFF) begin miscompares++; $display("FAIL srai_data: got %h want ffffffff", obs_data); end
    issue(i_type(12'h005, 5'd1, 3'b001, 5'd6, OPIMM), 32'h0, 32'h00000003, 32'h0);
    vectors++; if (obs_sel !== 4'b0111 || obs_data !== 32'h60) begin miscompares++; $display("FAIL slli: got sel=%h data=%h want 7 60", obs_sel, obs_data); end
  endtask

  task automatic test_compare_upper();
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b010, 5'd7, OP), 32'h0, 32'hFFFFFFFF, 32'd1);
    vectors++; if (obs_sel !== 4'b0101 || obs_data !== 32'd1) begin miscompares++; $display("FAIL slt: got sel=%h data=%h want 5 1", obs_sel, obs_data); end
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b011, 5'd7, OP), 32'h0, 32'hFFFFFFFF, 32'd1);
    vectors++; if (obs_sel !== 4'b0110 || obs_data !== 32'd0) begin miscompares++; $display("FAIL sltu: got sel=%h data=%h want 6 0", obs_sel, obs_data); end
    issue({20'h12345, 5'd5, 7'b0110111}, 32'h0, 32'hDEADBEEF, 32'h0);
    vectors++; if (obs_sel !== 4'b1111 || obs_a !== 32'h12345000 || obs_b !== 32'h0) begin
      miscompares++; $display("FAIL lui_ops: got sel=%h opA=%h opB=%h want f 12345000 0", obs_sel, obs_a, obs_b); end
    vectors++; if (obs_data !== 32'h12345000 || obs_rd !== 5'd5) begin miscompares++; $display("FAIL lui_data: got %h rd=%0d want 12345000 5", obs_data, obs_rd); end
    issue({20'h00001, 5'd8, 7'b0010111}, 32'h100, 32'h0, 32'h0);
    vectors++; if (obs_sel !== 4'b0000 || obs_a !== 32'h100 || obs_b !== 32'h1000) begin
      miscompares++; $display("FAIL auipc_ops: got sel=%h opA=%h opB=%h want 0 100 1000", obs_sel, obs_a, obs_b); end
    vectors++; if (obs_data !== 32'h1100) begin miscompares++; $display("FAIL auipc_data: got %h want 1100", obs_data); end
    issue(i_type(12'hFFF, 5'd1, 3'b000, 5'd9, OPIMM), 32'h0, 32'd10, 32'h0);
    vectors++; if (obs_ill !== 1'b0 || obs_data !== 32'd9) begin miscompares++; $display("FAIL addi_neg: got ill=%b data=%h want 0 9", obs_ill, obs_data); end
  endtask

  task automatic test_illegal();
    issue(i_type(12'h004, 5'd1, 3'b010, 5'd9, 7'b0000011), 32'h40, 32'h55, 32'h66);
    vectors++; if (obs_ill !== 1'b1 || obs_we !== 1'b0 || obs_data !== 32'h0) begin
      miscompares++; $display("FAIL illegal_load: got ill=%b we=%b data=%h want 1 0 0", obs_ill, obs_we, obs_data); end
    vectors++; if (obs_sel !== 4'b1111 || obs_a !== 32'h0 || obs_b !== 32'h0) begin
      miscompares++; $display("FAIL illegal_ops: got sel=%h opA=%h opB=%h want f 0 0", obs_sel, obs_a, obs_b); end
    issue(r_type(7'b0000001, 5'd2, 5'd1, 3'b000, 5'd9, OP), 32'h0, 32'd3, 32'd4);
    vectors++; if (obs_ill !== 1'b1 || obs_we !== 1'b0 || obs_data !== 32'h0) begin
      miscompares++; $display("FAIL illegal_f7: got ill=%b we=%b data=%h want 1 0 0", obs_ill, obs_we, obs_data); end
    issue(i_type(12'h023, 5'd1, 3'b101, 5'd9, OPIMM), 32'h0, 32'h80, 32'h0);
    vectors++; if (obs_ill !== 1'b1 || obs_data !== 32'h0) begin miscompares++; $display("FAIL illegal_srli_f7: got ill=%b data=%h want 1 0", obs_ill, obs_data); end
    issue(r_type(7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP), 32'h0, 32'd2, 32'd3);
    vectors++; if (obs_we !== 1'b0 || obs_ill !== 1'b0 || obs_data !== 32'd5) begin
      miscompares++; $display("FAIL add_x0: got we=%b ill=%b data=%h want 0 0 5", obs_we, obs_ill, obs_data); end
  endtask

  task automatic test_backpressure();
    int next = 0;
    int nret = 0;
    logic [31:0] got [4];
    int rcyc [4];
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      wbReady = (c >= 3);
      if (next < 4) begin
        inValid = 1'b1;
        inInstr = i_type(12'(next + 1), 5'd1, 3'b000, 5'(10 + next), OPIMM);
        inRs1   = 32'd100;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (c == 2) begin
        vectors++; if (inReady !== 1'b0 || next !== 2) begin miscompares++; $display("FAIL bp_ready: got inReady=%b accepted=%0d want 0 2", inReady, next); end
        vectors++; if (wbValid !== 1'b1 || wbData !== 32'd101) begin miscompares++; $display("FAIL bp_wb_stall: got v=%b data=%h want 1 65", wbValid, wbData); end
      end
      if (c == 3) begin
        vectors++; if (wbData !== 32'd101 || opB !== 32'd2 || wbRd !== 5'd10) begin
          miscompares++; $display("FAIL bp_hold: got data=%h opB=%h rd=%0d want 65 2 10", wbData, opB, wbRd); end
      end
      if (wbValid && wbReady) begin
        if (nret < 4) begin
          got[nret]  = wbData;
          rcyc[nret] = c;
        end
        nret++;
        $display("txn retire cycle=%0d rd=%0d data=%h", c, wbRd, wbData);
      end
      if (inValid && inReady) next++;
    end
    inValid = 1'b0;
    vectors++; if (nret !== 4) begin miscompares++; $display("FAIL bp_count: got %0d retirements want 4", nret); end
    if (nret >= 4) begin
      for (int k = 0; k < 4; k++) begin
        vectors++; if (got[k] !== 32'(101 + k) || rcyc[k] !== 3 + k) begin
          miscompares++; $display("FAIL bp_order%0d: got data=%h cycle=%0d want %h %0d", k, got[k], rcyc[k], 32'(101 + k), 3 + k); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int next = 0;
    int nret = 0;
    logic [31:0] got [3];
    int rcyc [3];
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      wbReady = 1'b1;
      if (next < 3) begin
        inValid = 1'b1;
        inInstr = i_type(12'(10 * (next + 1)), 5'd1, 3'b000, 5'(20 + next), OPIMM);
        inRs1   = 32'd1;
      end else begin
        inValid = 1'b0;
      end
      #1;
      if (wbValid) begin
        if (nret < 3) begin
          got[nret]  = wbData;
          rcyc[nret] = c;
        end
        nret++;
        $display("txn b2b retire cycle=%0d rd=%0d data=%h", c, wbRd, wbData);
      end
      if (inValid && inReady) next++;
    end
    inValid = 1'b0;
    vectors++; if (nret !== 3) begin miscompares++; $display("FAIL b2b_count: got %0d want 3", nret); end
    if (nret >= 3) begin
      for (int k = 0; k < 3; k++) begin
        vectors++; if (got[k] !== 32'(10 * (k + 1) + 1) || rcyc[k] !== 2 + k) begin
          miscompares++; $display("FAIL b2b_order%0d: got data=%h cycle=%0d want %h %0d", k, got[k], rcyc[k], 32'(10 * (k + 1) + 1), 2 + k); end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seen;
    @(negedge clk);
    wbReady = 1'b0;
    inValid = 1'b1;
    inInstr = i_type(12'h011, 5'd1, 3'b000, 5'd12, OPIMM);
    inRs1   = 32'h1000;
    @(negedge clk);
    inInstr = i_type(12'h022, 5'd1, 3'b000, 5'd13, OPIMM);
    @(negedge clk);
    inValid = 1'b0;
    vectors++; if (wbValid !== 1'b1 || inReady !== 1'b0) begin miscompares++; $display("FAIL rstmid_full: got v=%b ready=%b want 1 0", wbValid, inReady); end
    #2;
    rst = 1'b1;
    #1;
    vectors++; if (wbValid !== 1'b0 || inReady !== 1'b1) begin miscompares++; $display("FAIL rstmid_valid: got v=%b ready=%b want 0 1", wbValid, inReady); end
    vectors++; if (aluOutSel !== 4'b1111 || opA !== 32'h0 || opB !== 32'h0 || wbData !== 32'h0 || wbRd !== 5'd0 || wbWe !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_regs: got sel=%h opA=%h opB=%h data=%h rd=%0d we=%b want f 0 0 0 0 0", aluOutSel, opA, opB, wbData, wbRd, wbWe); end
    @(negedge clk);
    rst = 1'b0;
    wbReady = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (wbValid) seen = 1'b1;
    end
    vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rstmid_stale: wbValid seen=%b want 0", seen); end
    $display("txn reset mid-operation done");
    issue(r_type(7'b0100000, 5'd2, 5'd1, 3'b000, 5'd14, OP), 32'h0, 32'd10, 32'd3);
    vectors++; if (obs_sel !== 4'b0001 || obs_data !== 32'd7 || obs_rd !== 5'd14) begin
      miscompares++; $display("FAIL rstmid_resume: got sel=%h data=%h rd=%0d want 1 7 14", obs_sel, obs_data, obs_rd); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_shift();
    test_compare_upper();
    test_illegal();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that drives the combinational ALU. It accepts RV32I integer instructions with their operand values over a valid/ready handshake. It decodes each one into `aluOutSel`, `opA` and `opB`, presents them to the ALU, and captures `aluOut` into a writeback register. It sits between register-file read and writeback and is the initiator side of the ALU's select/operand interface.

## Interface
- `XLEN`, 32, datapath width; only 32 is supported.
- `clk` input 1: single clock, all registers on the rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `inValid` input 1: instruction and operands valid.
- `inReady` output 1: stage can accept this cycle.
- `inInstr` input 32: RV32I instruction word.
- `inPc` input 32: PC of the instruction (AUIPC).
- `inRs1` input 32: rs1 register value.
- `inRs2` input 32: rs2 register value.
- `aluOutSel` output 4: ALU select, registered.
- `opA` output 32: ALU operand A, registered.
- `opB` output 32: ALU operand B, registered.
- `aluOut` input 32: combinational ALU result for the current `aluOutSel`/`opA`/`opB`.
- `wbValid` output 1: writeback result valid.
- `wbReady` input 1: writeback consumer accepts.
- `wbRd` output 5: destination register.
- `wbWe` output 1: write enable; 0 when rd = x0 or the instruction is illegal.
- `wbData` output 32: result.
- `wbIllegal` output 1: instruction was not a supported ALU op.

## Operation
- **Select codes:**
  - 0000 ADD, 0001 SUB, 0010 XOR, 0011 OR, 0100 AND.
  - 0101 SLT (signed), 0110 SLTU (unsigned).
  - 0111 SLL, 1000 SRL, 1001 SRA.
  - 1111 PASS (result = `opA`).
- **OP (opcode 0110011):** `opA`=rs1, `opB`=rs2.
  - funct3/funct7 map per RV32I: SUB and SRA need funct7=0100000; all others need funct7=0000000.
  - Any other funct7 is illegal.
- **OP-IMM (0010011):** `opA`=rs1, `opB`=sign-extended imm[11:0].
  - SLLI needs funct7=0000000; SRLI/SRAI are selected by funct7 0000000/0100000, and any other funct7 is illegal.
  - ADDI, SLTI, SLTIU, XORI, ORI and ANDI ignore funct7.
- **Shift amount:** for every shift (OP and OP-IMM), `opB` is zero-extended bits [4:0] of the amount; upper bits are forced to 0.
- **LUI (0110111):** sel=PASS, `opA`={imm[31:12],12'h0}, `opB`=0.
- **AUIPC (0010111):** sel=ADD, `opA`=inPc, `opB`={imm[31:12],12'h0}.
- **Illegal (any other opcode, or a bad funct7):** sel=PASS, `opA`=0, `opB`=0, illegal flag carried; `wbData`=0, `wbWe`=0, `wbIllegal`=1.
- **Pipeline:** two registered stages.
  - S1 holds `aluOutSel`/`opA`/`opB`/rd/we/illegal and an `s1Valid` bit.
  - S2 holds the `wb*` outputs and `wbValid`.
- **Handshake:**
  - Input transfer when `inValid`&&`inReady`; writeback transfer when `wbValid`&&`wbReady`.
  - `s1Adv` = `s1Valid` && (!`wbValid` || `wbReady`).
  - `inReady` = !`s1Valid` || `s1Adv` (combinational, no dependence on `inValid`).
  - S2 loads `aluOut` when `s1Adv`.
  - `wbValid` clears on a writeback transfer without a new `s1Adv`.
  - S1 loads on an input transfer; `s1Valid` clears on `s1Adv` without a new input transfer.
- **Stall:** while `wbValid`&&!`wbReady`, all S1 and S2 registers hold and `inReady`=0 if `s1Valid`.
- **Idle:** when `s1Valid`=0, `aluOutSel`/`opA`/`opB` hold their last values; they are don't-care for correctness.

## Timing
- **Reset values:**
  - `aluOutSel`=4'b1111, `opA`=0, `opB`=0.
  - `wbValid`=0, `wbRd`=0, `wbWe`=0, `wbData`=0, `wbIllegal`=0, `s1Valid`=0.
  - `inReady`=1 after reset.
- **Latency:** an instruction accepted at edge N appears on ALU ports after N; `wbValid`=1 after edge N+1 (2 cycles, no backpressure).
- **Throughput:** 1 instruction/cycle with `wbReady` held high.
- **Simultaneous events:** writeback transfer and a new S1 result in the same cycle → S2 reloads, `wbValid` stays 1; input transfer and `s1Adv` in the same cycle → S1 reloads, `s1Valid` stays 1.
- **Reset mid-operation:** asserting `rst` drops all in-flight instructions immediately (asynchronous). No `wbValid` is produced for them after release.
- **ALU path:** `aluOut` is sampled in the same cycle S1 presents operands; the ALU must settle within one clock.

## Test plan
- **ADD:** ADD x3,x1,x2 with rs1=5, rs2=7 → `aluOutSel`=0000 one cycle after accept; `wbValid`, `wbRd`=3, `wbData`=12, `wbWe`=1 two cycles after accept.
- **Shift masking:** SRA with rs1=0x80000000, rs2=0xFFFFFF24 → `opB`=4, sel=1001. SRAI shamt 31 on 0x80000000 → `wbData`=0xFFFFFFFF.
- **SLT/SLTU:** with rs1=0xFFFFFFFF, rs2=1 → sel 0101 then 0110. LUI x5,0x12345 → `wbData`=0x12345000. AUIPC imm 0x1 at pc=0x100 → `wbData`=0x1100.
- **Backpressure:** stream 4 ADDIs with `wbReady`=0 for 3 cycles → `inReady` falls after 2 accepted. Outputs hold stable with no lost or duplicated result. Release → results retire in order, one per cycle.
- **Illegal:** opcode 0000011 and OP with funct7=0000001 → `wbIllegal`=1, `wbWe`=0, `wbData`=0. ADD to x0 → `wbWe`=0.
- **Reset mid-operation:** assert `rst` asynchronously with S1 and S2 full → `wbValid`=0 immediately and all outputs at reset values. No stale result after release.
